// File: rtl/mem_arb_pkg.sv
// Shared state and owner encodings for the two-port RAM arbiter.
// Used by mem_arb_grant and mem_port_arbiter.
package mem_arb_pkg;

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] READ_WAIT = 2'd1;
   localparam logic [1:0] RESP      = 2'd2;

   typedef enum logic [1:0] {
      StIdle     = IDLE,
      StReadWait = READ_WAIT,
      StResp     = RESP
   } arb_state_e;

   localparam logic OWNER_I = 1'b0;
   localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational winner selection between the I and D ports.
// ARB_ROUND_ROBIN_EN: alternate on contention; otherwise D always beats I.
module mem_arb_grant
   import mem_arb_pkg::*;
(
   input  logic i_req_i,
   input  logic d_req_i,
   input  logic last_grant_i,
   output logic grant_o,
   output logic winner_o
);

`ifdef ARB_ROUND_ROBIN_EN
   always_comb begin
      grant_o  = i_req_i | d_req_i;
      winner_o = OWNER_I;
      if (i_req_i && d_req_i) begin
         winner_o = ~last_grant_i;
      end else if (d_req_i) begin
         winner_o = OWNER_D;
      end
   end
`else
   // last_grant is tracked by the top in both builds but only consumed by round robin.
   logic unused_last_grant;
   assign unused_last_grant = last_grant_i;

   always_comb begin
      grant_o  = i_req_i | d_req_i;
      winner_o = d_req_i ? OWNER_D : OWNER_I;
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between an instruction-fetch port and a data port.
// Arbitration policy selected in mem_arb_grant by ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    i_req_i,
   input  logic [ADDR_WIDTH-1:0]   i_addr_i,
   output logic [DATA_WIDTH-1:0]   i_rdata_o,
   output logic                    i_ack_o,
   input  logic                    d_req_i,
   input  logic                    d_wr_i,
   input  logic [ADDR_WIDTH-1:0]   d_addr_i,
   input  logic [DATA_WIDTH-1:0]   d_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] d_wmask_i,
   output logic [DATA_WIDTH-1:0]   d_rdata_o,
   output logic                    d_ack_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic                    mem_rstrb_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   output logic [DATA_WIDTH/8-1:0] mem_wmask_o,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

   arb_state_e            state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  last_grant_q, last_grant_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
   logic                  grant;
   logic                  winner;

   mem_arb_grant u_grant (
      .i_req_i      (i_req_i),
      .d_req_i      (d_req_i),
      .last_grant_i (last_grant_q),
      .grant_o      (grant),
      .winner_o     (winner)
   );

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      mem_addr_o   = mem_addr_q;
      mem_rstrb_o  = 1'b0;
      mem_wdata_o  = '0;
      mem_wmask_o  = '0;
      i_ack_o      = 1'b0;
      d_ack_o      = 1'b0;

      case (state_q)
         StIdle: begin
            if (grant) begin
               owner_d      = winner;
               last_grant_d = winner;
               if (winner == OWNER_D && d_wr_i) begin
                  // Writes land in the grant cycle itself, so only the ack remains.
                  mem_addr_o  = d_addr_i;
                  mem_wdata_o = d_wdata_i;
                  mem_wmask_o = d_wmask_i;
                  state_d     = StResp;
               end else begin
                  mem_rstrb_o = 1'b1;
                  mem_addr_o  = (winner == OWNER_D) ? d_addr_i : i_addr_i;
                  state_d     = StReadWait;
               end
            end
         end
         StReadWait: begin
            if (owner_q == OWNER_D) begin
               d_rdata_d = mem_rdata_i;
            end else begin
               i_rdata_d = mem_rdata_i;
            end
            state_d = StResp;
         end
         StResp: begin
            i_ack_o = (owner_q == OWNER_I);
            d_ack_o = (owner_q == OWNER_D);
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= StIdle;
         owner_q      <= OWNER_I;
         last_grant_q <= OWNER_I;
         mem_addr_q   <= '0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         mem_addr_q   <= mem_addr_o;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   assign i_rdata_o = i_rdata_q;
   assign d_rdata_o = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a 1-cycle-latency RAM model.
// Contention expectations follow ARB_ROUND_ROBIN_EN when it is defined.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = DW / 8;

   typedef struct {
      bit            port;
      bit            chk;
      logic [DW-1:0] data;
      int            cyc;
   } ev_t;

   logic          clk = 1'b0;
   logic          reset, i_req, d_req, d_wr, i_ack, d_ack, mem_rstrb;
   logic [AW-1:0] i_addr, d_addr, mem_addr;
   logic [DW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
   logic [MW-1:0] d_wmask, mem_wmask;
   logic [DW-1:0] ram     [0:63];
   logic [DW-1:0] ref_ram [0:63];
   ev_t           sbq[$];
   ev_t           obs[$];
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;

   mem_port_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .i_req_i     (i_req),
      .i_addr_i    (i_addr),
      .i_rdata_o   (i_rdata),
      .i_ack_o     (i_ack),
      .d_req_i     (d_req),
      .d_wr_i      (d_wr),
      .d_addr_i    (d_addr),
      .d_wdata_i   (d_wdata),
      .d_wmask_i   (d_wmask),
      .d_rdata_o   (d_rdata),
      .d_ack_o     (d_ack),
      .mem_addr_o  (mem_addr),
      .mem_rstrb_o (mem_rstrb),
      .mem_wdata_o (mem_wdata),
      .mem_wmask_o (mem_wmask),
      .mem_rdata_i (mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (mem_rstrb) mem_rdata <= ram[mem_addr[7:2]];
      for (int b = 0; b < MW; b++) begin
         if (mem_wmask[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   always @(negedge clk) begin
      if (i_ack === 1'b1) obs.push_back('{port: 1'b0, chk: 1'b1, data: i_rdata, cyc: cyc});
      if (d_ack === 1'b1) obs.push_back('{port: 1'b1, chk: 1'b1, data: d_rdata, cyc: cyc});
   end

   task automatic cyc_start();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         cyc_start();
         mid();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle(3);
      checks++;
      if (i_ack !== 1'b0) begin
         errors++; $display("FAIL reset_i_ack: got %b, expected 0", i_ack);
      end
      checks++;
      if (d_ack !== 1'b0) begin
         errors++; $display("FAIL reset_d_ack: got %b, expected 0", d_ack);
      end
      checks++;
      if (mem_rstrb !== 1'b0) begin
         errors++; $display("FAIL reset_rstrb: got %b, expected 0", mem_rstrb);
      end
      checks++;
      if (mem_wmask !== 4'b0000) begin
         errors++; $display("FAIL reset_wmask: got %b, expected 0000", mem_wmask);
      end
      checks++;
      if (i_rdata !== 32'h0) begin
         errors++; $display("FAIL reset_i_rdata: got %h, expected 0", i_rdata);
      end
      checks++;
      if (d_rdata !== 32'h0) begin
         errors++; $display("FAIL reset_d_rdata: got %h, expected 0", d_rdata);
      end
      cyc_start();
      reset = 1'b0;
      mid();
      obs.delete();
      sbq.delete();
   endtask

   task automatic test_i_read();
      ev_t e, o;
      int  n;
      cyc_start();
      i_req  = 1'b1;
      i_addr = 32'h10;
      mid();
      n = cyc;
      checks++;
      if (mem_rstrb !== 1'b1 || mem_addr !== 32'h10) begin
         errors++;
         $display("FAIL iread_grant: got rstrb %b addr %h, expected 1 / 00000010",
                  mem_rstrb, mem_addr);
      end
      sbq.push_back('{port: 1'b0, chk: 1'b1, data: 32'h00A00513, cyc: n + 2});
      idle(2);
      cyc_start();
      i_req = 1'b0;
      mid();
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         checks++;
         if (obs.size() == 0) begin
            errors++; $display("FAIL iread_ack: got none, expected port %0d cycle %0d", e.port, e.cyc);
         end else begin
            o = obs.pop_front();
            if (o.port !== e.port || o.cyc != e.cyc || (e.chk && o.data !== e.data)) begin
               errors++;
               $display("FAIL iread_ack: got port %0d data %h cycle %0d, expected %0d %h %0d",
                        o.port, o.data, o.cyc, e.port, e.data, e.cyc);
            end
         end
      end
      checks++;
      if (obs.size() != 0) begin
         errors++; $display("FAIL iread_extra: got %0d extra acks, expected 0", obs.size());
      end
      obs.delete();
   endtask

   task automatic test_d_write();
      ev_t e, o;
      int  n;
      cyc_start();
      d_req   = 1'b1;
      d_wr    = 1'b1;
      d_addr  = 32'h20;
      d_wdata = 32'hDEADBEEF;
      d_wmask = 4'b0011;
      mid();
      n = cyc;
      checks++;
      if (mem_wmask !== 4'b0011 || mem_addr !== 32'h20 || mem_wdata !== 32'hDEADBEEF
          || mem_rstrb !== 1'b0) begin
         errors++;
         $display("FAIL dwr_grant: got wmask %b addr %h wdata %h rstrb %b, expected 0011 20 DEADBEEF 0",
                  mem_wmask, mem_addr, mem_wdata, mem_rstrb);
      end
      sbq.push_back('{port: 1'b1, chk: 1'b0, data: '0, cyc: n + 1});
      cyc_start();
      mid();
      checks++;
      if (mem_wmask !== 4'b0000) begin
         errors++; $display("FAIL dwr_mask_pulse: got %b one cycle later, expected 0000", mem_wmask);
      end
      cyc_start();
      d_req   = 1'b0;
      d_wr    = 1'b0;
      d_wmask = 4'b0000;
      mid();
      ref_ram[8] = 32'h1122BEEF;
      cyc_start();
      d_req = 1'b1;
      mid();
      n = cyc;
      sbq.push_back('{port: 1'b1, chk: 1'b1, data: ref_ram[8], cyc: n + 2});
      idle(2);
      cyc_start();
      d_req = 1'b0;
      mid();
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         checks++;
         if (obs.size() == 0) begin
            errors++; $display("FAIL dwr_ack: got none, expected port %0d cycle %0d", e.port, e.cyc);
         end else begin
            o = obs.pop_front();
            if (o.port !== e.port || o.cyc != e.cyc || (e.chk && o.data !== e.data)) begin
               errors++;
               $display("FAIL dwr_ack: got port %0d data %h cycle %0d, expected %0d %h %0d",
                        o.port, o.data, o.cyc, e.port, e.data, e.cyc);
            end
         end
      end
      checks++;
      if (obs.size() != 0) begin
         errors++; $display("FAIL dwr_extra: got %0d extra acks, expected 0", obs.size());
      end
      obs.delete();
   endtask

   task automatic test_contention();
      ev_t           e, o;
      int            n;
      bit            first_d;
      logic [AW-1:0] first_addr, second_addr;
`ifdef ARB_ROUND_ROBIN_EN
      first_d = 1'b0;
`else
      first_d = 1'b1;
`endif
      first_addr  = first_d ? 32'h18 : 32'h14;
      second_addr = first_d ? 32'h14 : 32'h18;
      cyc_start();
      i_req  = 1'b1;
      i_addr = 32'h14;
      d_req  = 1'b1;
      d_wr   = 1'b0;
      d_addr = 32'h18;
      mid();
      n = cyc;
      checks++;
      if (mem_rstrb !== 1'b1 || mem_addr !== first_addr) begin
         errors++;
         $display("FAIL cont_first: got rstrb %b addr %h, expected 1 / %h", mem_rstrb, mem_addr,
                  first_addr);
      end
      sbq.push_back('{port: first_d, chk: 1'b1, data: ref_ram[first_addr[7:2]], cyc: n + 2});
      sbq.push_back('{port: ~first_d, chk: 1'b1, data: ref_ram[second_addr[7:2]], cyc: n + 5});
      idle(2);
      cyc_start();
      if (first_d) d_req = 1'b0;
      else i_req = 1'b0;
      mid();
      checks++;
      if (mem_rstrb !== 1'b1 || mem_addr !== second_addr) begin
         errors++;
         $display("FAIL cont_second: got rstrb %b addr %h, expected 1 / %h", mem_rstrb, mem_addr,
                  second_addr);
      end
      idle(2);
      cyc_start();
      i_req = 1'b0;
      d_req = 1'b0;
      mid();
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         checks++;
         if (obs.size() == 0) begin
            errors++; $display("FAIL cont_ack: got none, expected port %0d cycle %0d", e.port, e.cyc);
         end else begin
            o = obs.pop_front();
            if (o.port !== e.port || o.cyc != e.cyc || (e.chk && o.data !== e.data)) begin
               errors++;
               $display("FAIL cont_ack: got port %0d data %h cycle %0d, expected %0d %h %0d",
                        o.port, o.data, o.cyc, e.port, e.data, e.cyc);
            end
         end
      end
      checks++;
      if (obs.size() != 0) begin
         errors++; $display("FAIL cont_extra: got %0d extra acks, expected 0", obs.size());
      end
      obs.delete();
   endtask

   task automatic test_back_to_back();
      ev_t e, o;
      int  n;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         cyc_start();
         i_req  = 1'b1;
         i_addr = 32'(4 * (k + 1));
         mid();
         if (k == 0) n = cyc;
         checks++;
         if (mem_rstrb !== 1'b1 || mem_addr !== i_addr) begin
            errors++;
            $display("FAIL b2b_grant: req %0d got rstrb %b addr %h, expected 1 / %h", k,
                     mem_rstrb, mem_addr, i_addr);
         end
         sbq.push_back('{port: 1'b0, chk: 1'b1, data: ref_ram[k + 1], cyc: n + 3 * k + 2});
         idle(2);
      end
      cyc_start();
      i_req = 1'b0;
      mid();
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         checks++;
         if (obs.size() == 0) begin
            errors++; $display("FAIL b2b_ack: got none, expected port %0d cycle %0d", e.port, e.cyc);
         end else begin
            o = obs.pop_front();
            if (o.port !== e.port || o.cyc != e.cyc || (e.chk && o.data !== e.data)) begin
               errors++;
               $display("FAIL b2b_ack: got port %0d data %h cycle %0d, expected %0d %h %0d",
                        o.port, o.data, o.cyc, e.port, e.data, e.cyc);
            end
         end
      end
      checks++;
      if (obs.size() != 0) begin
         errors++; $display("FAIL b2b_extra: got %0d extra acks, expected 0", obs.size());
      end
      obs.delete();
   endtask

   task automatic test_zero_mask();
      ev_t e, o;
      int  n;
      cyc_start();
      d_req   = 1'b1;
      d_wr    = 1'b1;
      d_addr  = 32'h24;
      d_wdata = 32'hFFFFFFFF;
      d_wmask = 4'b0000;
      mid();
      n = cyc;
      checks++;
      if (mem_wmask !== 4'b0000 || mem_rstrb !== 1'b0) begin
         errors++;
         $display("FAIL zmask_grant: got wmask %b rstrb %b, expected 0000 / 0", mem_wmask,
                  mem_rstrb);
      end
      sbq.push_back('{port: 1'b1, chk: 1'b0, data: '0, cyc: n + 1});
      cyc_start();
      mid();
      cyc_start();
      d_req = 1'b0;
      d_wr  = 1'b0;
      mid();
      cyc_start();
      d_req = 1'b1;
      mid();
      n = cyc;
      sbq.push_back('{port: 1'b1, chk: 1'b1, data: ref_ram[9], cyc: n + 2});
      idle(2);
      cyc_start();
      d_req = 1'b0;
      mid();
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         checks++;
         if (obs.size() == 0) begin
            errors++; $display("FAIL zmask_ack: got none, expected port %0d cycle %0d", e.port, e.cyc);
         end else begin
            o = obs.pop_front();
            if (o.port !== e.port || o.cyc != e.cyc || (e.chk && o.data !== e.data)) begin
               errors++;
               $display("FAIL zmask_ack: got port %0d data %h cycle %0d, expected %0d %h %0d",
                        o.port, o.data, o.cyc, e.port, e.data, e.cyc);
            end
         end
      end
      checks++;
      if (obs.size() != 0) begin
         errors++; $display("FAIL zmask_extra: got %0d extra acks, expected 0", obs.size());
      end
      obs.delete();
   endtask

   task automatic test_reset_mid();
      ev_t e, o;
      int  n;
      cyc_start();
      i_req  = 1'b1;
      i_addr = 32'h30;
      mid();
      cyc_start();
      reset = 1'b1;
      mid();
      cyc_start();
      reset = 1'b0;
      i_req = 1'b0;
      mid();
      checks++;
      if (i_ack !== 1'b0 || mem_rstrb !== 1'b0 || i_rdata !== 32'h0) begin
         errors++;
         $display("FAIL rstmid_state: got ack %b rstrb %b rdata %h, expected 0 0 0", i_ack,
                  mem_rstrb, i_rdata);
      end
      idle(3);
      cyc_start();
      i_req = 1'b1;
      mid();
      n = cyc;
      checks++;
      if (mem_rstrb !== 1'b1 || mem_addr !== 32'h30) begin
         errors++;
         $display("FAIL rstmid_regrant: got rstrb %b addr %h, expected 1 / 00000030", mem_rstrb,
                  mem_addr);
      end
      sbq.push_back('{port: 1'b0, chk: 1'b1, data: ref_ram[12], cyc: n + 2});
      idle(2);
      cyc_start();
      i_req = 1'b0;
      mid();
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         checks++;
         if (obs.size() == 0) begin
            errors++; $display("FAIL rstmid_ack: got none, expected port %0d cycle %0d", e.port, e.cyc);
         end else begin
            o = obs.pop_front();
            if (o.port !== e.port || o.cyc != e.cyc || (e.chk && o.data !== e.data)) begin
               errors++;
               $display("FAIL rstmid_ack: got port %0d data %h cycle %0d, expected %0d %h %0d",
                        o.port, o.data, o.cyc, e.port, e.data, e.cyc);
            end
         end
      end
      checks++;
      if (obs.size() != 0) begin
         errors++; $display("FAIL rstmid_extra: got %0d extra acks, expected 0", obs.size());
      end
      obs.delete();
   endtask

   initial begin
      for (int w = 0; w < 64; w++) begin
         ram[w] = {8'(w), 8'hC0, 8'(w) ^ 8'h5A, 8'h3C};
      end
      ram[4] = 32'h00A00513;
      ram[8] = 32'h11223344;
      for (int w = 0; w < 64; w++) ref_ram[w] = ram[w];
      reset   = 1'b1;
      i_req   = 1'b0;
      i_addr  = '0;
      d_req   = 1'b0;
      d_wr    = 1'b0;
      d_addr  = '0;
      d_wdata = '0;
      d_wmask = '0;

      test_reset();
      test_i_read();
      test_d_write();
      test_contention();
      test_back_to_back();
      test_zero_mask();
      test_reset_mid();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
